// File: rtl/hdb3_encoder.sv
// -----------------------------------------------------------------------------
// hdb3_encoder
//
// Transmit-side HDB3 line coder. It takes a serial NRZ bit stream, one bit per
// data_valid beat, and produces 2-bit ternary symbols. Marks are AMI coded.
// Every run of four zeros is replaced by 000V or B00V.
//
// The coder keeps a 4-entry look-ahead pipeline. When the fourth zero of a run
// arrives, the first zero of that run is still inside the pipeline, so it can
// be tagged as a B pulse before it is emitted. Each emitted symbol is the entry
// leaving the oldest pipeline stage. A bit accepted on beat k is therefore
// presented on the cycle after beat k+4.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   data_valid  nrz_in carries a valid bit this cycle
//   nrz_in      NRZ data bit
//   hdb3_out    2'b01 = +1, 2'b10 = -1, 2'b00 = zero (2'b11 is never driven)
//   hdb3_valid  one-cycle strobe marking a new symbol on hdb3_out
//   subst_cnt   number of V symbols emitted, saturating
//               (present only when HDB3_ENC_SUBST_CNT_EN is defined)
//
// Optional feature macro: HDB3_ENC_SUBST_CNT_EN
// -----------------------------------------------------------------------------
module hdb3_encoder #(
  parameter logic FIRST_POS = 1'b1,
  parameter int   CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic             nrz_in,
  output logic [1:0]       hdb3_out,
  output logic             hdb3_valid
`ifdef HDB3_ENC_SUBST_CNT_EN
  ,
  output logic [CNT_W-1:0] subst_cnt
`endif
);

  // Map a pulse polarity (1 = positive) onto the symbol bus code.
  function automatic logic [1:0] pulse_sym(input logic pos);
    return pos ? 2'b01 : 2'b10;
  endfunction

  logic [3:0] sr_q,    sr_d;
  logic [3:0] v_tag_q, v_tag_d;
  logic [3:0] b_tag_q, b_tag_d;
  logic [1:0] zcnt_q,  zcnt_d;
  logic       par_q,   par_d;
  logic [2:0] fill_q,  fill_d;
  logic       last_pol_q, last_pol_d;
  logic [1:0] out_q,   out_d;
  logic       valid_q, valid_d;
  logic       subst;
  logic       emit_pol;

  always_comb begin
    sr_d       = sr_q;
    v_tag_d    = v_tag_q;
    b_tag_d    = b_tag_q;
    zcnt_d     = zcnt_q;
    par_d      = par_q;
    fill_d     = fill_q;
    last_pol_d = last_pol_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    subst      = 1'b0;
    emit_pol   = last_pol_q;

    if (data_valid) begin
      // Input side: track the zero run and the mark parity since the last V.
      subst = !nrz_in && (zcnt_q == 2'd3);

      sr_d    = {sr_q[2:0], nrz_in};
      v_tag_d = {v_tag_q[2:0], subst};
      b_tag_d = {b_tag_q[2:0], 1'b0};

      if (nrz_in) begin
        zcnt_d = 2'd0;
        par_d  = ~par_q;
      end else if (subst) begin
        zcnt_d = 2'd0;
        par_d  = 1'b0;
        // Even marks since the last V: the oldest zero of this run is now
        // landing in sr[3] and becomes the balancing B pulse.
        if (!par_q) begin
          b_tag_d[3] = 1'b1;
        end
      end else begin
        zcnt_d = zcnt_q + 2'd1;
      end

      // Output side: the entry leaving sr[3] is encoded once the pipe is full.
      if (fill_q == 3'd4) begin
        valid_d = 1'b1;
        if (v_tag_q[3]) begin
          // Violation repeats the previous polarity and leaves it unchanged.
          emit_pol = last_pol_q;
          out_d    = pulse_sym(emit_pol);
        end else if (sr_q[3] || b_tag_q[3]) begin
          emit_pol   = ~last_pol_q;
          last_pol_d = emit_pol;
          out_d      = pulse_sym(emit_pol);
        end else begin
          out_d = 2'b00;
        end
      end else begin
        fill_d = fill_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= 4'd0;
      v_tag_q    <= 4'd0;
      b_tag_q    <= 4'd0;
      zcnt_q     <= 2'd0;
      par_q      <= 1'b0;
      fill_q     <= 3'd0;
      last_pol_q <= ~FIRST_POS;
      out_q      <= 2'b00;
      valid_q    <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      v_tag_q    <= v_tag_d;
      b_tag_q    <= b_tag_d;
      zcnt_q     <= zcnt_d;
      par_q      <= par_d;
      fill_q     <= fill_d;
      last_pol_q <= last_pol_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

  assign hdb3_out   = out_q;
  assign hdb3_valid = valid_q;

`ifdef HDB3_ENC_SUBST_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts in step with the symbol register, so it moves on the same edge
  // that raises hdb3_valid for a V symbol.
  always_comb begin
    cnt_d = cnt_q;
    if (data_valid && (fill_q == 3'd4) && v_tag_q[3] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign subst_cnt = cnt_q;
`else
  // The counter width only matters when the counter is built.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hdb3_encoder.sv
// -----------------------------------------------------------------------------
// tb_hdb3_encoder
//
// Scoreboard bench for hdb3_encoder. Directed cases push their expected symbol
// sequence before the stimulus is driven, and a negedge monitor pops and
// compares each symbol as hdb3_valid strobes. The random loopback case pushes
// the NRZ bits instead. The monitor runs the received symbols through an
// independent HDB3 decoder model: a pulse with the same polarity as the
// previous pulse is a V, and it clears itself and the three symbols before it.
// A second instance with FIRST_POS=0 is checked only in its own case.
// -----------------------------------------------------------------------------
module tb_hdb3_encoder;

  logic       clk;
  logic       rst;
  logic       data_valid;
  logic       nrz_in;
  logic [1:0] hdb3_out,   hdb3_out_n;
  logic       hdb3_valid, hdb3_valid_n;
`ifdef HDB3_ENC_SUBST_CNT_EN
  logic [15:0] subst_cnt, subst_cnt_n;
`endif

  hdb3_encoder #(.FIRST_POS(1'b1), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .nrz_in     (nrz_in),
    .hdb3_out   (hdb3_out),
    .hdb3_valid (hdb3_valid)
`ifdef HDB3_ENC_SUBST_CNT_EN
    ,
    .subst_cnt  (subst_cnt)
`endif
  );

  hdb3_encoder #(.FIRST_POS(1'b0), .CNT_W(16)) dut_n (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .nrz_in     (nrz_in),
    .hdb3_out   (hdb3_out_n),
    .hdb3_valid (hdb3_valid_n)
`ifdef HDB3_ENC_SUBST_CNT_EN
    ,
    .subst_cnt  (subst_cnt_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] exp_q[$];
  logic [1:0] expn_q[$];
  logic       bit_q[$];
  logic       dec_buf[$];

  bit   tog_mode  = 1'b0;
  bit   loop_mode = 1'b0;
  bit   chk_n     = 1'b0;
  logic prev_valid = 1'b0;
  bit   dec_have_last = 1'b0;
  logic dec_last_pol  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // "+" -> 01, "-" -> 10, "0" -> 00
  task automatic push_syms(input string s, input bit to_n);
    logic [1:0] v;
    for (int i = 0; i < s.len(); i++) begin
      v = (s[i] == "+") ? 2'b01 : (s[i] == "-") ? 2'b10 : 2'b00;
      if (to_n) expn_q.push_back(v);
      else      exp_q.push_back(v);
    end
  endtask

  // Called at a negedge; leaves data_valid low at a negedge.
  task automatic drive_bit(input logic b, input bit gap);
    data_valid = 1'b1;
    nrz_in     = b;
    @(negedge clk);
    data_valid = 1'b0;
    nrz_in     = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic drive_str(input string s, input bit gap);
    for (int i = 0; i < s.len(); i++) drive_bit(s[i] == "1", gap);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    check_val(tag, exp_q.size(), 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic rel;
    logic p;
    logic pol;
    if (!rst) begin
      if (tog_mode) check_val("no_back_to_back", {31'd0, hdb3_valid & prev_valid}, 0);
      prev_valid <= hdb3_valid;
      if (hdb3_valid) begin
        check_val("sym_legal", {31'd0, hdb3_out == 2'b11}, 0);
        if (loop_mode) begin
          if (dec_buf.size() == 4) begin
            rel = dec_buf.pop_front();
            if (bit_q.size() > 0) check_val("loopback_bit", {31'd0, rel}, {31'd0, bit_q.pop_front()});
          end
          p   = (hdb3_out != 2'b00);
          pol = (hdb3_out == 2'b01);
          if (p && dec_have_last && (pol == dec_last_pol)) begin
            foreach (dec_buf[i]) dec_buf[i] = 1'b0;
            dec_buf.push_back(1'b0);
          end else begin
            dec_buf.push_back(p);
          end
          if (p) begin
            dec_have_last = 1'b1;
            dec_last_pol  = pol;
          end
        end else if (exp_q.size() == 0) begin
          check_val("unexpected_symbol", {30'd0, hdb3_out}, 32'hffff_ffff);
        end else begin
          check_val("symbol", {30'd0, hdb3_out}, {30'd0, exp_q.pop_front()});
        end
      end
      if (chk_n && hdb3_valid_n) begin
        if (expn_q.size() == 0) check_val("unexpected_symbol_n", {30'd0, hdb3_out_n}, 32'hffff_ffff);
        else check_val("symbol_n", {30'd0, hdb3_out_n}, {30'd0, expn_q.pop_front()});
      end
    end else begin
      prev_valid <= 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    nrz_in     = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_valid", {31'd0, hdb3_valid}, 0);
    check_val("reset_out",   {30'd0, hdb3_out},   0);
`ifdef HDB3_ENC_SUBST_CNT_EN
    check_val("reset_subst_cnt", {16'd0, subst_cnt}, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // AMI marks then B00V with even parity.
    push_syms("+-+-+00+", 1'b0);
    drive_str("111100000000", 1'b0);
    drain("drain_ami_b00v");

    // Odd parity: 000V repeats the last polarity.
    apply_reset();
    push_syms("+000+", 1'b0);
    drive_str("100000000", 1'b0);
    drain("drain_000v");

    // Eight zeros: two B00V groups with alternating polarity.
    apply_reset();
    push_syms("+00+-00-", 1'b0);
    drive_str("000000000000", 1'b0);
    drain("drain_two_b00v");
`ifdef HDB3_ENC_SUBST_CNT_EN
    check_val("subst_cnt_two", {16'd0, subst_cnt}, 2);
`endif

    // Gapped input gives the same symbols as contiguous input.
    apply_reset();
    tog_mode = 1'b1;
    push_syms("+-+00+-", 1'b0);
    drive_str("11000010000", 1'b1);
    drain("drain_gapped");
    tog_mode = 1'b0;

    // Reset mid-stream while a symbol strobe is up and zcnt is 3.
    apply_reset();
    push_syms("+-+", 1'b0);
    drive_str("1111100", 1'b0);
    data_valid = 1'b1;
    nrz_in     = 1'b0;
    @(posedge clk);
    #2;
    data_valid = 1'b0;
    rst        = 1'b1;
    #1;
    check_val("midrst_valid", {31'd0, hdb3_valid}, 0);
    check_val("midrst_out",   {30'd0, hdb3_out},   0);
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_queue", exp_q.size(), 0);
    push_syms("+00+", 1'b0);
    drive_str("00000000", 1'b0);
    drain("drain_after_midrst");

    // FIRST_POS=0 instance starts with a negative mark.
    apply_reset();
    chk_n = 1'b1;
    push_syms("-+-", 1'b1);
    push_syms("+-+", 1'b0);
    drive_str("1110000", 1'b0);
    drain("drain_first_neg");
    check_val("drain_first_neg_n", expn_q.size(), 0);
    chk_n = 1'b0;

    // Random loopback through the decoder model, with random gaps.
    apply_reset();
    dec_buf.delete();
    dec_have_last = 1'b0;
    loop_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      bit_q.push_back(b);
      drive_bit(b, $urandom_range(0, 3) == 0);
    end
    drive_str("000000000000", 1'b0);
    repeat (4) @(negedge clk);
    check_val("loopback_all_bits", bit_q.size(), 0);
    loop_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hdb3_encoder.md
Name: hdb3_encoder

Overview:
- Transmit-side line coder that converts a serial NRZ bit stream into 2-bit ternary HDB3 symbols.
- Output format is exactly what the receive-side HDB3 decoder consumes (hdb3 symbol bus plus valid strobe), so the two blocks can be chained back-to-back in loopback.
- Applies AMI marking plus 000V/B00V substitution for every run of four zeros.
- Uses a 4-entry look-ahead pipeline so the B pulse can be placed ahead of the V pulse.

Parameters:
FIRST_POS, 1, 1: first mark after reset is emitted as +1; 0: emitted as -1
CNT_W, 16, width of substitution counter (used only with optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
data_valid  input  1  nrz_in is a valid bit this cycle (one bit per asserted cycle)
nrz_in  input  1  NRZ data bit
hdb3_out  output  2  symbol: 2'b01 = +1, 2'b10 = -1, 2'b00 = zero; 2'b11 never driven
hdb3_valid  output  1  one-cycle strobe, hdb3_out holds a new symbol
subst_cnt  output  CNT_W  number of V symbols emitted (only with HDB3_ENC_SUBST_CNT_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - sr[3:0], v_tag[3:0], b_tag[3:0] = 0.
  - zcnt = 0, par = 0, fill = 0.
  - last_pol = ~FIRST_POS, where last_pol=1 means the last pulse was +.
  - hdb3_out = 2'b00, hdb3_valid = 0, subst_cnt = 0.
- Pipeline: a 4-stage shift register sr with per-stage tags. sr[0] is the newest entry, sr[3] the oldest. It shifts only on cycles with data_valid=1; no other state changes when data_valid=0.
- Input side, evaluated on each valid beat using pre-shift state:
  - nrz_in=1: zcnt <= 0; par toggles.
  - nrz_in=0 and zcnt<3: zcnt increments.
  - nrz_in=0 and zcnt==3 (substitution):
    - new entry tagged V.
    - If par==0, the entry landing in sr[3] this beat (oldest zero of the run) gets a B tag.
    - zcnt <= 0, par <= 0.
- Output side, on each valid beat with fill==4: the entry leaving sr[3] (pre-shift) is encoded and registered:
  - data 1 or B tag: polarity = ~last_pol; last_pol updates.
  - V tag: polarity = last_pol (violation); last_pol unchanged.
  - otherwise: 2'b00.
- hdb3_valid = 1 for exactly the cycle after such a beat, else 0. hdb3_out holds its last value while hdb3_valid=0.
- Fill: fill saturates at 4. The first 4 beats after reset produce no output.
- Latency: the bit accepted on beat k is output on the cycle after beat k+4. Gaps in data_valid stretch latency in cycles but never in beats.
- No tag can reach sr[3] without having passed the B decision, so B and V never collide. A run of 8 zeros produces two independent substitutions.
- Reset mid-stream discards all pipeline contents and restarts fill. No partial symbol is emitted.

Optional Feature:
Macro HDB3_ENC_SUBST_CNT_EN.
- Defined: port subst_cnt exists. It increments by 1 in the cycle each V symbol is emitted (hdb3_valid with V tag), saturates at all-ones, and clears on rst.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, FIRST_POS=1, nrz 1,1,1,1,0,0,0,0 (contiguous valid), then 4 flush zeros -> symbols +,-,+,-,+,0,0,+ (par even, so B00V: B=+, V=+).
- Reset, nrz 1,0,0,0,0 + 4 zeros -> symbols +,0,0,0,+ (par odd, so 000V; V same as last +).
- Reset, 8 zeros + 4 zeros -> +,0,0,+,-,0,0,- (two consecutive B00V with alternating polarity); subst_cnt=2 with HDB3_ENC_SUBST_CNT_EN.
- Reset, nrz 1,1,0,0,0,0,1 with data_valid toggling 1/0 every cycle -> same symbols as contiguous input (+,-,+,0,0,+,-); hdb3_valid never on consecutive cycles; no output in the first 4 beats.
- Assert rst for 1 cycle mid-stream after 3 zeros with zcnt=3 -> hdb3_valid=0 and hdb3_out=00 immediately. Then nrz 0,0,0,0 + 4 zeros -> B00V with B=+, proving zcnt, par and last_pol were cleared.
- FIRST_POS=0, nrz 1,1,1 + 4 zeros -> -,+,- ; decoder loopback of 1000 random bits reproduces the input after 4-beat latency.
